// File: rtl/seg_hex_display.sv
// seg_hex_display: 8-digit time-multiplexed 7-segment driver for the calculator result.
// The input value and error flag are snapshotted once per scan frame, on the tick
// that ends digit 7, so one frame never mixes old and new results.
// Each digit is lit SCAN_DIV-1 cycles and then dark for one cycle, to avoid ghosting.
// Optional build macro LEADING_ZERO_BLANK_EN: blanks leading zero digits in normal mode.
// Digit 0 is always shown.

module seg_hex_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_g,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        error,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int            PW      = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [7:0]    SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [31:0]   r_shadow_val;
    logic          r_shadow_err;
    logic [7:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_tick;
    logic [3:0]    w_nibble;
    logic          w_blank_lz;
    logic [6:0]    w_glyph;
    logic [7:0]    w_seg_next;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign w_tick = (r_presc == P_LAST);

    // Slot prescaler and digit index; the index steps on every tick and wraps 7 -> 0.
    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Frame-boundary snapshot of the result and error flag.
    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= 32'd0;
            r_shadow_err <= 1'b0;
        end else if (w_tick && (r_idx == 3'd7)) begin
            r_shadow_val <= value;
            r_shadow_err <= error;
        end
    end

    assign w_nibble = r_shadow_val[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank_lz = (r_idx != 3'd0) && ((r_shadow_val >> {r_idx, 2'b00}) == 32'd0);
`else
    assign w_blank_lz = 1'b0;
`endif

    // Glyph for the current digit: "Err" pattern in error mode, hex nibble otherwise.
    always_comb begin
        w_glyph = 7'h00;
        if (r_shadow_err) begin
            case (r_idx)
                3'd2:       w_glyph = 7'h79;
                3'd1, 3'd0: w_glyph = 7'h50;
                default:    w_glyph = 7'h00;
            endcase
        end else if (!w_blank_lz) begin
            w_glyph = hex_glyph(w_nibble);
        end
    end

    assign w_seg_next = SEG_ACTIVE_LOW ? ~{1'b0, w_glyph} : {1'b0, w_glyph};

    // Registered outputs; the tick cycle turns all anodes off, and seg holds through it.
    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 8'hFF;
            r_seg <= SEG_OFF;
        end else if (w_tick) begin
            r_an  <= 8'hFF;
        end else begin
            r_an  <= ~(8'd1 << r_idx);
            r_seg <= w_seg_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_seg_hex_display.sv
// Bench for seg_hex_display with SCAN_DIV=4 and SEG_ACTIVE_LOW=1.
// The reference derives slot, digit and frame from the cycle count since reset.

module tb_seg_hex_display;

    localparam int D     = 4;
    localparam int FRAME = 8 * D;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] HEXG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk_g = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value = 32'd0;
    logic        error = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;

    seg_hex_display #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk_g (clk_g),
        .rst_n (rst_n),
        .value (value),
        .error (error),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk_g = ~clk_g;

    int          tests = 0;
    int          fails = 0;
    int          n     = 0;
    logic [31:0] m_val = 32'd0;
    logic        m_err = 1'b0;
    logic [7:0]  exp_an  = 8'hFF;
    logic [7:0]  exp_seg = 8'hFF;
    bit          exp_lit = 1'b0;

    function automatic logic [6:0] glyph_of(input int k, input logic [31:0] v, input logic e);
        if (e) begin
            if (k == 2) return 7'h79;
            if (k < 2)  return 7'h50;
            return 7'h00;
        end
        if (LZB && k >= 1 && (v >> (4 * k)) == 32'd0) return 7'h00;
        return HEXG[4'((v >> (4 * k)) & 32'hF)];
    endfunction

    // Reference: output after edge n comes from the state before it (slot, prescaler, frame snapshot).
    always @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            n       = 0;
            m_val   = 32'd0;
            m_err   = 1'b0;
            exp_an  = 8'hFF;
            exp_seg = 8'hFF;
            exp_lit = 1'b0;
        end else begin : mdl
            int p;
            int s;
            n = n + 1;
            p = (n - 1) % D;
            s = (n - 1) / D;
            if (p == D - 1) begin
                exp_an  = 8'hFF;
                exp_lit = 1'b0;
            end else begin
                exp_an  = ~(8'd1 << (s % 8));
                exp_seg = ~{1'b0, glyph_of(s % 8, m_val, m_err)};
                exp_lit = 1'b1;
            end
            if (n % FRAME == 0) begin
                m_val = value;
                m_err = error;
            end
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk_g) begin
        tests++;
        if (an !== exp_an) begin
            fails++;
            $display("FAIL an n=%0d: got %h expected %h", n, an, exp_an);
        end
        if (!rst_n || exp_lit) begin
            tests++;
            if (seg !== exp_seg) begin
                fails++;
                $display("FAIL seg n=%0d: got %h expected %h", n, seg, exp_seg);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] ex);
        tests++;
        if (got !== ex) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, ex);
        end
    endtask

    task automatic go_to(input int t);
        while (n < t) @(negedge clk_g);
    endtask

    initial begin
        repeat (3) @(negedge clk_g);
        rst_n = 1'b1;

        go_to(1);   chk("first_an", an, 8'hFE); chk("first_seg", seg, 8'hC0);
        go_to(4);   chk("dead_an", an, 8'hFF);
        go_to(5);   chk("dig1_an", an, 8'hFD); chk("dig1_seg", seg, 8'hC0);
        go_to(10);  value = 32'h1234ABCD;
        go_to(33);  chk("wrap_an", an, 8'hFE); chk("d0_D", seg, 8'hA1);
        go_to(49);  chk("d4_an", an, 8'hEF); chk("d4_4", seg, 8'h99);
        go_to(50);  value = 32'h0;
        go_to(77);  value = 32'hFFFFFFFF;
        go_to(85);  chk("d5_old", seg, LZB ? 8'hFF : 8'hC0);
        go_to(97);  chk("d0_F", seg, 8'h8E);
        go_to(100); error = 1'b1;
        go_to(129); chk("err_d0_r", seg, 8'hAF);
        go_to(137); chk("err_d2_an", an, 8'hFB); chk("err_d2_E", seg, 8'h86);
        go_to(140); error = 1'b0;
        go_to(157); chk("err_d7_an", an, 8'h7F); chk("err_d7_blank", seg, 8'hFF);
        go_to(161); chk("err_clear", seg, 8'h8E);

        go_to(182);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_an", an, 8'hFF); chk("rst_async_seg", seg, 8'hFF);
        repeat (2) @(negedge clk_g);
        rst_n = 1'b1;
        go_to(1);   chk("restart_an", an, 8'hFE); chk("restart_seg", seg, 8'hC0);

        go_to(5);   value = 32'h00000A05;
        go_to(33);  chk("lz_d0_5", seg, 8'h92);
        go_to(37);  chk("lz_d1_0", seg, 8'hC0);
        go_to(41);  chk("lz_d2_A", seg, 8'h88);
        go_to(45);  chk("lz_d3", seg, LZB ? 8'hFF : 8'hC0);
        go_to(46);  value = 32'h0;
        go_to(65);  chk("zero_d0", seg, 8'hC0);
        go_to(69);  chk("zero_d1", seg, LZB ? 8'hFF : 8'hC0);

        repeat (3000) begin
            @(negedge clk_g);
            if ($urandom_range(0, 15) == 0) value = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 63) == 0) error = ~error;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
